// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_e;

  localparam int unsigned TIMEOUT_W = 8;

  // Required value of the byte-address low bits for a word access.
  localparam logic [1:0]  WORD_ALIGN = 2'b00;
  localparam logic [31:0] FAULT_Y    = 32'h0;

  function automatic logic is_fault(input logic moe, input logic mwr, input logic [1:0] y_lo);
    return (moe & mwr) | ((moe | mwr) & (y_lo != WORD_ALIGN));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM input bundle, data-memory bus and MEM/WB result grouped for the access unit.
interface mem_access_unit_if #(
  parameter int unsigned AW = 32
) ();

  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_pc;
  logic          mem_moe;
  logic          mem_mwr;
  logic [31:0]   mem_y;
  logic [31:0]   mem_d;
  logic [31:0]   mem_id;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ack;

  logic          wb_valid;
  logic          wb_ready;
  logic [31:0]   wb_pc;
  logic [31:0]   wb_y;
  logic [31:0]   wb_id;
  logic          wb_err;

  modport slave (
    input  mem_valid, mem_pc, mem_moe, mem_mwr, mem_y, mem_d, mem_id,
    input  dm_rdata, dm_ack, wb_ready,
    output mem_ready, dm_req, dm_we, dm_addr, dm_wdata,
    output wb_valid, wb_pc, wb_y, wb_id, wb_err
  );

  modport master (
    output mem_valid, mem_pc, mem_moe, mem_mwr, mem_y, mem_d, mem_id,
    output dm_rdata, dm_ack, wb_ready,
    input  mem_ready, dm_req, dm_we, dm_addr, dm_wdata,
    input  wb_valid, wb_pc, wb_y, wb_id, wb_err
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Bus-wait counter: counts enabled cycles and flags the cycle on which the limit is reached.
module mem_timeout_ctr
  import mem_pkg::*;
#(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] Last = TIMEOUT_W'(Timeout - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flags the cycle whose increment would bring the count to Timeout.
  assign expired_o = enable_i & (count_q == Last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage unit: one word access per EX/MEM bundle over a req/ack bus, one result to MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  state_e        state_q;
  logic          dm_req_q;
  logic          dm_we_q;
  logic [AW-1:0] dm_addr_q;
  logic [31:0]   dm_wdata_q;
  logic          wb_valid_q;
  logic          wb_err_q;
  logic [31:0]   wb_pc_q;
  logic [31:0]   wb_y_q;
  logic [31:0]   wb_id_q;

  logic mem_ready;
  logic accept;
  logic fault;
  logic mem_op;
  logic in_bus;
  logic tmo_enable;
  logic tmo_clear;
  logic tmo_expired;

  always_comb begin
    // Gated by reset so every output reads 0 while reset is held.
    mem_ready  = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & bus.wb_ready));
    accept     = bus.mem_valid & mem_ready;
    fault      = is_fault(bus.mem_moe, bus.mem_mwr, bus.mem_y[1:0]);
    mem_op     = (bus.mem_moe | bus.mem_mwr) & ~fault;
    in_bus     = (state_q == BUS);
    tmo_enable = in_bus & ~bus.dm_ack;
    tmo_clear  = ~in_bus | bus.dm_ack | tmo_expired;
  end

  mem_timeout_ctr #(
    .Timeout (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_pc_q    <= '0;
      wb_y_q     <= '0;
      wb_id_q    <= '0;
    end else if (accept) begin
      wb_pc_q <= bus.mem_pc;
      wb_id_q <= bus.mem_id;
      if (mem_op) begin
        state_q    <= BUS;
        dm_req_q   <= 1'b1;
        dm_we_q    <= bus.mem_mwr;
        dm_addr_q  <= bus.mem_y[AW-1:0];
        dm_wdata_q <= bus.mem_d;
        wb_valid_q <= 1'b0;
        wb_err_q   <= 1'b0;
        // Stores return Y; loads overwrite this with read data on ack.
        wb_y_q     <= bus.mem_y;
      end else begin
        state_q    <= HOLD;
        wb_valid_q <= 1'b1;
        wb_err_q   <= fault;
        wb_y_q     <= fault ? FAULT_Y : bus.mem_y;
      end
    end else begin
      case (state_q)
        BUS: begin
          if (bus.dm_ack) begin
            state_q    <= HOLD;
            dm_req_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b0;
            if (!dm_we_q) begin
              wb_y_q <= bus.dm_rdata;
            end
          end else if (tmo_expired) begin
            state_q    <= HOLD;
            dm_req_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_err_q   <= 1'b1;
            wb_y_q     <= FAULT_Y;
          end
        end
        HOLD: begin
          if (bus.wb_ready) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.dm_req    = dm_req_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.dm_wdata  = dm_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_err    = wb_err_q;
  assign bus.wb_pc     = wb_pc_q;
  assign bus.wb_y      = wb_y_q;
  assign bus.wb_id     = wb_id_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed bundles, bus responder and result monitor.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] pc, y, id;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;
    int          len;
    bit          abandon;
  } bus_exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_exp_t  sb[$];
  bus_exp_t bq[$];
  bus_exp_t cur;
  bit       cur_valid;
  int       req_cnt;

  mem_access_unit_if #(.AW(32)) bus_if ();

  mem_access_unit #(
    .AW      (32),
    .TIMEOUT (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one bundle at a negedge, wait for acceptance, queue its expectations.
  task automatic send(input logic [31:0] pc, input logic moe, input logic mwr,
                      input logic [31:0] y, input logic [31:0] d, input logic [31:0] id,
                      input logic [31:0] exp_y, input logic exp_err,
                      input bit is_mem, input int ack_at, input int len,
                      input logic [31:0] rdata, input bit abandon);
    int       guard;
    wb_exp_t  w;
    bus_exp_t b;
    guard            = 0;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_pc    = pc;
    bus_if.mem_moe   = moe;
    bus_if.mem_mwr   = mwr;
    bus_if.mem_y     = y;
    bus_if.mem_d     = d;
    bus_if.mem_id    = id;
    #1;
    while (!bus_if.mem_ready && guard < 64) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=mem_ready_low required=accept pc=%h", pc);
    end else begin
      w.pc  = pc;
      w.y   = exp_y;
      w.id  = id;
      w.err = exp_err;
      if (!abandon) sb.push_back(w);
      if (is_mem) begin
        b.we      = mwr;
        b.addr    = y;
        b.wdata   = d;
        b.rdata   = rdata;
        b.ack_at  = ack_at;
        b.len     = len;
        b.abandon = abandon;
        bq.push_back(b);
      end
    end
    @(negedge clk);
    bus_if.mem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor and bus responder, sampling 3 time units after the negedge.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus_if.wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=%h required=no_result", bus_if.wb_y);
      end else begin
        chk("wb_pc", bus_if.wb_pc, sb[0].pc);
        chk("wb_y", bus_if.wb_y, sb[0].y);
        chk("wb_id", bus_if.wb_id, sb[0].id);
        chk("wb_err", {31'b0, bus_if.wb_err}, {31'b0, sb[0].err});
        if (bus_if.wb_ready) void'(sb.pop_front());
      end
    end
    if (rst_n && bus_if.dm_req) begin
      if (req_cnt == 0) begin
        if (bq.size() == 0) begin
          cur_valid = 1'b0;
          checks++;
          failures++;
          $display("FAIL bus_unexpected actual=dm_req_high addr=%h required=no_request",
                   bus_if.dm_addr);
        end else begin
          cur       = bq.pop_front();
          cur_valid = 1'b1;
        end
      end
      if (cur_valid) begin
        chk("dm_we", {31'b0, bus_if.dm_we}, {31'b0, cur.we});
        chk("dm_addr", bus_if.dm_addr, cur.addr);
        chk("dm_wdata", bus_if.dm_wdata, cur.wdata);
      end
      req_cnt++;
      bus_if.dm_ack   = cur_valid && (cur.ack_at == req_cnt);
      bus_if.dm_rdata = cur_valid ? cur.rdata : 32'h0;
    end else begin
      if (req_cnt > 0 && cur_valid && !cur.abandon) chk("dm_req_len", req_cnt, cur.len);
      req_cnt       = 0;
      cur_valid     = 1'b0;
      bus_if.dm_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks           = 0;
    failures         = 0;
    req_cnt          = 0;
    cur_valid        = 1'b0;
    bus_if.mem_valid = 1'b0;
    bus_if.mem_pc    = '0;
    bus_if.mem_moe   = 1'b0;
    bus_if.mem_mwr   = 1'b0;
    bus_if.mem_y     = '0;
    bus_if.mem_d     = '0;
    bus_if.mem_id    = '0;
    bus_if.dm_rdata  = '0;
    bus_if.dm_ack    = 1'b0;
    bus_if.wb_ready  = 1'b1;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    idle(2);
    #1;
    chk("rst_dm_req", {31'b0, bus_if.dm_req}, 32'h0);
    chk("rst_dm_addr", bus_if.dm_addr, 32'h0);
    chk("rst_wb_valid", {31'b0, bus_if.wb_valid}, 32'h0);
    chk("rst_wb_y", bus_if.wb_y, 32'h0);
    chk("rst_wb_err", {31'b0, bus_if.wb_err}, 32'h0);
    chk("rst_mem_ready", {31'b0, bus_if.mem_ready}, 32'h0);
    #1 rst_n = 1'b1;
    idle(1);
    #1;
    chk("ready_after_rst", {31'b0, bus_if.mem_ready}, 32'h1);
    idle(1);

    // Pass-through, three back-to-back bundles
    send(32'h40, 0, 0, 32'h1234, 32'h0, 32'h13, 32'h1234, 0, 0, 0, 0, 32'h0, 0);
    send(32'h44, 0, 0, 32'h1234, 32'h0, 32'h14, 32'h1234, 0, 0, 0, 0, 32'h0, 0);
    send(32'h48, 0, 0, 32'h1234, 32'h0, 32'h15, 32'h1234, 0, 0, 0, 0, 32'h0, 0);
    idle(2);

    // Load, ack on third request cycle
    send(32'h50, 1, 0, 32'h100, 32'h0, 32'h21, 32'hDEADBEEF, 0, 1, 3, 3, 32'hDEADBEEF, 0);
    #1;
    chk("ready_in_bus", {31'b0, bus_if.mem_ready}, 32'h0);
    idle(5);

    // Store, ack on first request cycle
    send(32'h54, 0, 1, 32'h204, 32'hCAFEF00D, 32'h22, 32'h204, 0, 1, 1, 1, 32'h0, 0);
    idle(3);

    // Faults: misaligned load, and load+store together
    send(32'h58, 1, 0, 32'h102, 32'h0, 32'h23, 32'h0, 1, 0, 0, 0, 32'h0, 0);
    send(32'h5C, 1, 1, 32'h0, 32'h0, 32'h24, 32'h0, 1, 0, 0, 0, 32'h0, 0);
    idle(3);

    // Timeout (limit 4) with no ack, then ack exactly on the fourth cycle
    send(32'h60, 1, 0, 32'h300, 32'h0, 32'h25, 32'h0, 1, 1, 0, 4, 32'h0, 0);
    idle(8);
    send(32'h64, 1, 0, 32'h304, 32'h0, 32'h26, 32'h11223344, 0, 1, 4, 4, 32'h11223344, 0);
    idle(8);

    // Backpressure: result held for five cycles
    bus_if.wb_ready = 1'b0;
    send(32'h80, 0, 0, 32'h55, 32'h0, 32'h99, 32'h55, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ready_in_hold", {31'b0, bus_if.mem_ready}, 32'h0);
      @(negedge clk);
    end
    bus_if.wb_ready = 1'b1;
    idle(2);

    // Asynchronous reset in the middle of a bus access
    send(32'h90, 1, 0, 32'h400, 32'h0, 32'h27, 32'h0, 0, 1, 0, 0, 32'h0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus_dm_req", {31'b0, bus_if.dm_req}, 32'h0);
    chk("rst_bus_wb_valid", {31'b0, bus_if.wb_valid}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_bus_rst", {31'b0, bus_if.mem_ready}, 32'h1);
    idle(1);

    // Unit still works after the abandoned access
    send(32'hC0, 0, 0, 32'h77, 32'h0, 32'h28, 32'h77, 0, 0, 0, 0, 32'h0, 0);
    idle(6);

    chk("sb_drained", sb.size(), 32'h0);
    chk("bus_drained", bq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
